// File: rtl/pc8001_extmem_bridge.sv
// rtl/pc8001_extmem_bridge.sv - pc8001 external bus to synchronous SRAM/BRAM request/ack bridge
module pc8001_extmem_bridge #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter bit          CS1_READONLY = 1'b1,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic        I_CLK_21M,
  input  logic        I_RESET,
  input  logic [14:0] I_A,
  input  logic [7:0]  I_D,
  input  logic        I_nRD,
  input  logic        I_nWR,
  input  logic        I_nCS1,
  input  logic        I_nCS2,
  output logic [7:0]  O_D,
  output logic        O_D_OE,
  output logic        O_nWAIT,
  output logic [15:0] O_MEM_A,
  output logic [7:0]  O_MEM_WD,
  output logic        O_MEM_WE,
  output logic        O_MEM_REQ,
  input  logic        I_MEM_ACK,
  input  logic [7:0]  I_MEM_Q,
  output logic        O_TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] nrd_sync_q, nwr_sync_q, ncs1_sync_q, ncs2_sync_q;

  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  d_q, d_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d;
  logic        rdir_q, rdir_d;
  logic        to_q, to_d;
  logic        nwait;

  logic rd_s, wr_s, cs1_s, cs2_s;
  logic sel, region, rd, wr;

  // Strobes idle high, so the synchronizers reset to 1 to avoid a phantom access.
  always_ff @(posedge I_CLK_21M) begin
    if (I_RESET) begin
      nrd_sync_q  <= '1;
      nwr_sync_q  <= '1;
      ncs1_sync_q <= '1;
      ncs2_sync_q <= '1;
    end else begin
      nrd_sync_q  <= {nrd_sync_q[SYNC_STAGES-2:0], I_nRD};
      nwr_sync_q  <= {nwr_sync_q[SYNC_STAGES-2:0], I_nWR};
      ncs1_sync_q <= {ncs1_sync_q[SYNC_STAGES-2:0], I_nCS1};
      ncs2_sync_q <= {ncs2_sync_q[SYNC_STAGES-2:0], I_nCS2};
    end
  end

  assign rd_s  = nrd_sync_q[SYNC_STAGES-1];
  assign wr_s  = nwr_sync_q[SYNC_STAGES-1];
  assign cs1_s = ncs1_sync_q[SYNC_STAGES-1];
  assign cs2_s = ncs2_sync_q[SYNC_STAGES-1];

  // nCS1 has priority, so the region bit is only 1 when nCS1 is inactive.
  assign sel    = !cs1_s || !cs2_s;
  assign region = cs1_s;
  assign rd     = sel && !rd_s;
  assign wr     = sel && !wr_s && rd_s;

  always_ff @(posedge I_CLK_21M) begin
    if (I_RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      d_q     <= 8'd0;
      a_q     <= 16'd0;
      wd_q    <= 8'd0;
      we_q    <= 1'b0;
      rdir_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rdir_q  <= rdir_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    a_d     = a_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rdir_d  = rdir_q;
    to_d    = to_q;
    nwait   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rd || wr) begin
          nwait  = 1'b0;
          a_d    = {region, I_A};
          wd_d   = I_D;
          we_d   = wr;
          rdir_d = rd;
          if (wr && CS1_READONLY && !region) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        nwait = 1'b0;
        cnt_d = cnt_q + 8'd1;
        // An ack in the final counted cycle still completes normally.
        if (I_MEM_ACK) begin
          if (rdir_q) begin
            d_d = I_MEM_Q;
          end
          state_d = S_DONE;
        end else if (cnt_d == TIMEOUT) begin
          to_d = 1'b1;
          if (rdir_q) begin
            d_d = 8'hFF;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if ((rd_s && wr_s) || !sel) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign O_D       = d_q;
  assign O_D_OE    = (state_q == S_DONE) && rdir_q;
  assign O_nWAIT   = nwait;
  assign O_MEM_A   = a_q;
  assign O_MEM_WD  = wd_q;
  assign O_MEM_WE  = we_q;
  assign O_MEM_REQ = (state_q == S_REQ);
  assign O_TIMEOUT = to_q;

endmodule
